bus_port_fifo: RTL

Per-device port buffer sitting directly upstream and downstream of `bs_gnrtr_n_rbtr`, one instance per driver slot. Its TX queue holds packets written by the device and presents them to the bus arbiter through `pndng`/`pop`/`D_pop`. Its RX queue captures packets the bus delivers through `push`/`D_push` and hands them to the device. It also checks each received destination ID against the port's own ID and the broadcast ID.

---
 rtl/bus_pkg.sv | 16 +
 rtl/sync_fifo.sv | 76 +++++++
 rtl/bus_port_fifo.sv | 112 +++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the bus port buffers: destination ID width,
// broadcast ID, packet type and destination extraction.
package bus_pkg;

  localparam int ID_W    = 8;
  localparam int PCKG_SZ = 16;

  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

  typedef logic [PCKG_SZ-1:0] pkt_t;

  function automatic logic [ID_W-1:0] dest_of(input pkt_t pkt);
    return pkt[PCKG_SZ-1 -: ID_W];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head is presented combinationally whenever
// the queue holds data, and reads 0 when it is empty.
module sync_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr,
  input  logic [width-1:0]         i_wr_data,
  input  logic                     i_rd,
  output logic [width-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(depth):0]   o_count,
  output logic                     o_wr_ok,
  output logic                     o_ovf,
  output logic                     o_udf
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(depth);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [width-1:0] r_mem [depth];

  logic w_empty;
  logic w_full;
  logic w_rd_ok;
  logic w_wr_ok;

  assign w_empty = (r_count == {(AW+1){1'b0}});
  assign w_full  = (r_count == FULL_CNT);
  assign w_rd_ok = i_rd & ~w_empty;
  // A write into a full queue is still taken when the head leaves the same cycle.
  assign w_wr_ok = i_wr & (~w_full | w_rd_ok);

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are only observable through the gated head.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data = w_empty ? {width{1'b0}} : r_mem[r_rd_ptr];
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_count   = r_count;
  assign o_wr_ok   = w_wr_ok;
  assign o_ovf     = i_wr & ~w_wr_ok;
  assign o_udf     = i_rd & w_empty;

endmodule

// File: rtl/bus_port_fifo.sv
// Per-device bus port: TX queue toward the arbiter, RX queue from the bus,
// destination check on received packets, drop counter and sticky error flags.
module bus_port_fifo
  import bus_pkg::*;
#(
  parameter int              pckg_sz   = 16,
  parameter int              depth     = 8,
  parameter logic [ID_W-1:0] id        = 8'h00,
  parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dev_wr,
  input  logic [pckg_sz-1:0]       dev_wr_data,
  output logic                     tx_full,
  output logic                     pndng,
  output logic [pckg_sz-1:0]       D_pop,
  input  logic                     pop,
  input  logic                     push,
  input  logic [pckg_sz-1:0]       D_push,
  input  logic                     dev_rd,
  output logic [pckg_sz-1:0]       dev_rd_data,
  output logic                     rx_empty,
  output logic [$clog2(depth):0]   rx_count,
  output logic                     tx_ovf,
  output logic                     rx_ovf,
  output logic                     tx_udf,
  output logic                     misroute,
  output logic [7:0]               drop_cnt
);

  logic                   w_tx_empty;
  logic                   w_tx_ovf;
  logic                   w_tx_udf;
  logic [$clog2(depth):0] w_tx_count_unused;
  logic                   w_tx_wr_ok_unused;
  logic                   w_rx_wr_ok;
  logic                   w_rx_ovf;
  logic                   w_rx_full_unused;
  logic                   w_rx_udf_unused;
  logic [ID_W-1:0]        w_dest;
  logic                   w_misroute;

  logic       r_tx_ovf;
  logic       r_rx_ovf;
  logic       r_tx_udf;
  logic       r_misroute;
  logic [7:0] r_drop_cnt;

  sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .i_wr      (dev_wr),
    .i_wr_data (dev_wr_data),
    .i_rd      (pop),
    .o_rd_data (D_pop),
    .o_full    (tx_full),
    .o_empty   (w_tx_empty),
    .o_count   (w_tx_count_unused),
    .o_wr_ok   (w_tx_wr_ok_unused),
    .o_ovf     (w_tx_ovf),
    .o_udf     (w_tx_udf)
  );

  sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .i_wr      (push),
    .i_wr_data (D_push),
    .i_rd      (dev_rd),
    .o_rd_data (dev_rd_data),
    .o_full    (w_rx_full_unused),
    .o_empty   (rx_empty),
    .o_count   (rx_count),
    .o_wr_ok   (w_rx_wr_ok),
    .o_ovf     (w_rx_ovf),
    .o_udf     (w_rx_udf_unused)
  );

  // Only packets that actually land in the RX queue are route-checked.
  assign w_dest     = D_push[pckg_sz-1 -: ID_W];
  assign w_misroute = w_rx_wr_ok & (w_dest != id) & (w_dest != broadcast);

  // Sticky error flags and the saturating drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_ovf   <= 1'b0;
      r_rx_ovf   <= 1'b0;
      r_tx_udf   <= 1'b0;
      r_misroute <= 1'b0;
      r_drop_cnt <= 8'h00;
    end else begin
      r_tx_ovf   <= r_tx_ovf   | w_tx_ovf;
      r_rx_ovf   <= r_rx_ovf   | w_rx_ovf;
      r_tx_udf   <= r_tx_udf   | w_tx_udf;
      r_misroute <= r_misroute | w_misroute;
      if (w_rx_ovf && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'h01;
      end else begin
        r_drop_cnt <= r_drop_cnt;
      end
    end
  end

  assign pndng    = ~w_tx_empty;
  assign tx_ovf   = r_tx_ovf;
  assign rx_ovf   = r_rx_ovf;
  assign tx_udf   = r_tx_udf;
  assign misroute = r_misroute;
  assign drop_cnt = r_drop_cnt;

endmodule
